// File: rtl/compositor_pkg.sv
// compositor_pkg: shared widths, config address map and reset defaults for the layer compositor
package compositor_pkg;
    localparam int R_W    = 3;
    localparam int G_W    = 3;
    localparam int B_W    = 2;
    localparam int PX_W   = R_W + G_W + B_W;
    localparam int ADDR_W = 4;
    localparam int DATA_W = PX_W + 1;
    typedef struct packed {
        logic            en;
        logic [PX_W-1:0] key;
    } layer_cfg_t;
    localparam layer_cfg_t      LAYER_RST = '{en: 1'b1, key: 8'h00};
    localparam logic [PX_W-1:0] BG_RST    = 8'h00;
    // Layers occupy addresses 0..n-1; the background register sits right after them.
    function automatic logic [ADDR_W-1:0] layer_addr(input int i);
        return ADDR_W'(i);
    endfunction
    function automatic logic [ADDR_W-1:0] bg_addr(input int n);
        return ADDR_W'(n);
    endfunction
endpackage

// File: rtl/color_expand.sv
// color_expand: RGB332 to RGB888 expansion; zero channel stays 0, nonzero channel is padded with ones
// Ports: px = {r[2:0],g[2:0],b[1:0]} in; r/g/b = 8-bit expanded channels out (combinational).
module color_expand
    import compositor_pkg::*;
(
    input  logic [PX_W-1:0] px,
    output logic [7:0]      r,
    output logic [7:0]      g,
    output logic [7:0]      b
);
    logic [R_W-1:0] rc;
    logic [G_W-1:0] gc;
    logic [B_W-1:0] bc;
    assign {rc, gc, bc} = px;
    assign r = (rc == '0) ? 8'h00 : {rc, {(8-R_W){1'b1}}};
    assign g = (gc == '0) ? 8'h00 : {gc, {(8-G_W){1'b1}}};
    assign b = (bc == '0) ? 8'h00 : {bc, {(8-B_W){1'b1}}};
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: two-stage priority compositor of RGB332 layers with vsync-shadowed config
// Ports: clk/reset (sync, active-high); hs_in/vs_in/blank_in timing; layer_px packed layers (layer 0 wins);
//        cfg_we/cfg_addr/cfg_data config writes; r/g/b_out colour, hs/vs/blank_out timing (2-cycle latency);
//        frame_drawn one-cycle pulse after each vsync leading edge.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int N_LAYERS  = 3,
    parameter bit VS_ACTIVE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hs_in,
    input  logic                     vs_in,
    input  logic                     blank_in,
    input  logic [N_LAYERS*PX_W-1:0] layer_px,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]        cfg_data,
    output logic [7:0]               r_out,
    output logic [7:0]               g_out,
    output logic [7:0]               b_out,
    output logic                     hs_out,
    output logic                     vs_out,
    output logic                     blank_out,
    output logic                     frame_drawn
);
    layer_cfg_t               sh_cfg  [N_LAYERS];
    layer_cfg_t               act_cfg [N_LAYERS];
    layer_cfg_t               nxt_cfg [N_LAYERS];
    logic [PX_W-1:0]          sh_bg, act_bg, nxt_bg;
    logic                     vs_prev, vs_edge;
    logic [N_LAYERS-1:0]      opaque;
    logic [N_LAYERS*PX_W-1:0] s1_px;
    logic [N_LAYERS-1:0]      s1_opq;
    logic [PX_W-1:0]          s1_bg, sel;
    logic                     s1_hs, s1_vs, s1_blank;
    logic [7:0]               r_e, g_e, b_e;
    assign vs_edge = (vs_in == VS_ACTIVE) && (vs_prev != VS_ACTIVE);
    // nxt_* is the shadow value including this cycle's write, so an edge-cycle write reaches the active copy.
    always_comb begin
        for (int i = 0; i < N_LAYERS; i++) begin
            nxt_cfg[i] = (cfg_we && cfg_addr == layer_addr(i)) ? layer_cfg_t'(cfg_data) : sh_cfg[i];
            opaque[i]  = act_cfg[i].en && (layer_px[i*PX_W +: PX_W] != act_cfg[i].key);
        end
        nxt_bg = (cfg_we && cfg_addr == bg_addr(N_LAYERS)) ? cfg_data[PX_W-1:0] : sh_bg;
    end
    // Lowest index wins: scan from the top so later (lower) indices overwrite.
    always_comb begin
        sel = s1_bg;
        for (int i = N_LAYERS - 1; i >= 0; i--)
            sel = s1_opq[i] ? s1_px[i*PX_W +: PX_W] : sel;
    end
    color_expand u_expand (
        .px (sel),
        .r  (r_e),
        .g  (g_e),
        .b  (b_e)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_cfg      <= '{default: LAYER_RST};
            act_cfg     <= '{default: LAYER_RST};
            sh_bg       <= BG_RST;
            act_bg      <= BG_RST;
            vs_prev     <= VS_ACTIVE;
            s1_px       <= '0;
            s1_opq      <= '0;
            s1_bg       <= BG_RST;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_blank    <= 1'b1;
            r_out       <= 8'h00;
            g_out       <= 8'h00;
            b_out       <= 8'h00;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            blank_out   <= 1'b1;
            frame_drawn <= 1'b0;
        end else begin
            sh_cfg      <= nxt_cfg;
            sh_bg       <= nxt_bg;
            if (vs_edge) begin
                act_cfg <= nxt_cfg;
                act_bg  <= nxt_bg;
            end
            vs_prev     <= vs_in;
            s1_px       <= layer_px;
            s1_opq      <= opaque;
            s1_bg       <= act_bg;
            s1_hs       <= hs_in;
            s1_vs       <= vs_in;
            s1_blank    <= blank_in;
            r_out       <= s1_blank ? 8'h00 : r_e;
            g_out       <= s1_blank ? 8'h00 : g_e;
            b_out       <= s1_blank ? 8'h00 : b_e;
            hs_out      <= s1_hs;
            vs_out      <= s1_vs;
            blank_out   <= s1_blank;
            frame_drawn <= vs_edge;
        end
    end
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: table vectors plus scoreboarded sequences for the layer compositor
module tb_layer_compositor;
    localparam int N = 3;
    logic         clk = 1'b0;
    logic         reset, hs_in, vs_in, blank_in, cfg_we;
    logic [N*8-1:0] layer_px;
    logic [3:0]   cfg_addr;
    logic [8:0]   cfg_data;
    logic [7:0]   r_out, g_out, b_out;
    logic         hs_out, vs_out, blank_out, frame_drawn;
    layer_compositor #(.N_LAYERS(N), .VS_ACTIVE(1'b1)) dut (
        .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
        .layer_px(layer_px), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .hs_out(hs_out), .vs_out(vs_out),
        .blank_out(blank_out), .frame_drawn(frame_drawn)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [23:0] rgb;
        logic [2:0]  tim;
    } exp_t;
    typedef struct {
        logic [23:0] px;
        logic        hs;
        logic        blank;
        logic [23:0] rgb;
    } vec_t;
    exp_t       q[$];
    vec_t       vecs[8];
    logic [8:0] m_sh[N], m_act[N];
    logic [7:0] m_bg_sh, m_bg_act;
    logic       m_vs_prev;
    int         checks = 0, errors = 0, pulses = 0;
    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [23:0] model_rgb(input logic [23:0] px, input logic blank);
        logic [7:0] c;
        logic       found;
        c = m_bg_act;
        found = 1'b0;
        for (int i = 0; i < N; i++)
            if (!found && m_act[i][8] && px[8*i +: 8] != m_act[i][7:0]) begin
                c = px[8*i +: 8];
                found = 1'b1;
            end
        if (blank) return 24'h0;
        return {(c[7:5] == 0) ? 8'h00 : {c[7:5], 5'b11111},
                (c[4:2] == 0) ? 8'h00 : {c[4:2], 5'b11111},
                (c[1:0] == 0) ? 8'h00 : {c[1:0], 6'b111111}};
    endfunction
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh[i] = 9'h100;
            m_act[i] = 9'h100;
        end
        m_bg_sh = 8'h00;
        m_bg_act = 8'h00;
        m_vs_prev = 1'b1;
        q.delete();
    endtask
    task automatic step(input logic [23:0] px, input logic hs, input logic vs, input logic blank,
                        input logic we, input logic [3:0] addr, input logic [8:0] data,
                        input logic use_tab, input logic [23:0] tab_rgb);
        exp_t e;
        logic edge_v;
        layer_px = px; hs_in = hs; vs_in = vs; blank_in = blank;
        cfg_we = we; cfg_addr = addr; cfg_data = data;
        e.rgb = use_tab ? tab_rgb : model_rgb(px, blank);
        e.tim = {hs, vs, blank};
        q.push_back(e);
        edge_v = vs && !m_vs_prev;
        m_vs_prev = vs;
        if (we && addr < N) m_sh[addr] = data;
        if (we && addr == N) m_bg_sh = data[7:0];
        if (edge_v) begin
            m_act = m_sh;
            m_bg_act = m_bg_sh;
        end
        @(posedge clk);
        #1;
        pulses += int'(frame_drawn);
        check("frame_drawn", {23'h0, frame_drawn}, {23'h0, edge_v});
        if (q.size() == 2) begin
            e = q.pop_front();
            check("colour", {r_out, g_out, b_out}, e.rgb);
            check("timing", {21'h0, hs_out, vs_out, blank_out}, {21'h0, e.tim});
        end
        cfg_we = 1'b0;
    endtask
    task automatic do_reset(input logic vs);
        reset = 1'b1; vs_in = vs; hs_in = 1'b0; blank_in = 1'b0; layer_px = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        @(posedge clk);
        #1;
        check("rst_colour", {r_out, g_out, b_out}, 24'h0);
        check("rst_timing", {21'h0, hs_out, vs_out, blank_out}, 24'h1);
        check("rst_frame", {23'h0, frame_drawn}, 24'h0);
        model_reset();
        reset = 1'b0;
    endtask
    initial begin
        vecs[0] = '{24'h031CE0, 1'b1, 1'b0, 24'hFF0000};
        vecs[1] = '{24'h031C00, 1'b0, 1'b0, 24'h00FF00};
        vecs[2] = '{24'h030000, 1'b1, 1'b0, 24'h0000FF};
        vecs[3] = '{24'h000000, 1'b0, 1'b0, 24'h000000};
        vecs[4] = '{24'h000024, 1'b1, 1'b0, 24'h3F3F00};
        vecs[5] = '{24'h000049, 1'b0, 1'b0, 24'h5F5F7F};
        vecs[6] = '{24'h031CE0, 1'b1, 1'b1, 24'h000000};
        vecs[7] = '{24'h0000FF, 1'b0, 1'b0, 24'hFFFFFF};
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(24'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step(vecs[i].px, vecs[i].hs, 0, vecs[i].blank, 0, 0, 0, 1, vecs[i].rgb);
        step(24'h0, 0, 0, 0, 1, 4'd3, 9'h003, 0, 0);
        for (int i = 0; i < 4; i++) step(24'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("shadow_hold", {r_out, g_out, b_out}, 24'h0);
        for (int i = 0; i < 4; i++) step(24'h0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("shadow_apply", {r_out, g_out, b_out}, 24'h0000FF);
        for (int i = 0; i < 4; i++) step(24'h031C00, 0, 0, 0, 0, 0, 0, 0, 0);
        check("layer1_on", {r_out, g_out, b_out}, 24'h00FF00);
        step(24'h031C00, 0, 1, 0, 1, 4'd1, 9'h000, 0, 0);
        for (int i = 0; i < 3; i++) step(24'h031C00, 0, 1, 0, 0, 0, 0, 0, 0);
        check("bypass_off", {r_out, g_out, b_out}, 24'h0000FF);
        for (int i = 0; i < 3; i++) step(24'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) step(24'h0, i % 20 == 0, 1, 0, 0, 0, 0, 0, 0);
        check("one_pulse", 24'(pulses), 24'd1);
        for (int i = 0; i < 3; i++) step(24'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset(1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) step(24'h0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("no_pulse_after_reset", 24'(pulses), 24'd0);
        for (int i = 0; i < 300; i++)
            step(24'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? !vs_in : vs_in,
                 1'($urandom), $urandom_range(0, 7) == 0, 4'($urandom_range(0, 4)), 9'($urandom), 0, 0);
        for (int i = 0; i < 2; i++) step(24'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
